// File: rtl/intlv_quad_buf.sv
// Interleaver quad buffer: stores one soft symbol per cycle, drains four per request.
// Optional macro INTLV_QUAD_BUF_LEN_CHK_EN enables the write-count vs pb_len check (err[1]).
module intlv_quad_buf #(
  parameter int DW    = 6,
  parameter int AW    = 12,
  parameter int DEPTH = 2688
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [DW-1:0]   din,
  input  logic            wen,
  input  logic [AW-1:0]   enable,
  input  logic [AW-1:0]   pb_offset,
  input  logic [AW-1:0]   pb_len,
  input  logic            rd_req,
  output logic [4*DW-1:0] dout,
  output logic            dout_vld,
  output logic            done,
  output logic            busy,
  output logic [1:0]      err
);

  localparam int MAW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_X = (AW+2)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   mem [DEPTH];
  logic [4*DW-1:0] dout_q, dout_d;
  logic            dout_vld_q, dout_vld_d;
  logic            done_q, done_d;
  logic [1:0]      err_q, err_d;
  logic [AW-1:0]   wr_cnt_q, wr_cnt_d;

  logic [AW:0]     wa;
  logic [AW:0]     ra;
  logic [AW+1:0]   ra_end;
  logic [AW+1:0]   rd_addr;
  logic [4*DW-1:0] rd_data;
  logic            wa_ok;
  logic            ra_ovf;
  logic            rd_issue;
  logic            rd_last;
  logic            mem_we;

  assign wa       = {1'b0, pb_offset} + {1'b0, enable};
  assign ra       = {1'b0, pb_offset} + {enable[AW-2:0], 2'b00};
  assign ra_end   = {1'b0, ra} + (AW+2)'(3);
  assign wa_ok    = {1'b0, wa} < DEPTH_X;
  assign ra_ovf   = ra_end >= DEPTH_X;
  assign rd_issue = rd_req && (state_q != ST_IDLE);
  assign rd_last  = ({1'b0, enable} + (AW+1)'(1)) == ({1'b0, pb_len} >> 2);
  assign mem_we   = wen && wa_ok;

  // Buffer storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wa[MAW-1:0]] <= din;
    end
  end

  // Out-of-range lanes read as zero; registering this gives read-before-write.
  always_comb begin
    rd_data = '0;
    rd_addr = '0;
    for (int k = 0; k < 4; k++) begin
      rd_addr = {1'b0, ra} + (AW+2)'(k);
      if (rd_addr < DEPTH_X) begin
        rd_data[k*DW +: DW] = mem[rd_addr[MAW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
      wr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    wr_cnt_d   = wr_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (wen) begin
          state_d  = ST_FILL;
          err_d    = '0;
          wr_cnt_d = '0;
        end
      end
      ST_FILL: begin
        if (rd_req) begin
          state_d = rd_last ? ST_IDLE : ST_DRAIN;
`ifdef INTLV_QUAD_BUF_LEN_CHK_EN
          if (wr_cnt_q != pb_len) begin
            err_d[1] = 1'b1;
          end
`endif
        end
      end
      ST_DRAIN: begin
        if (rd_req && rd_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wen) begin
      if (wa_ok) begin
        if (wr_cnt_d != '1) begin
          wr_cnt_d = wr_cnt_d + AW'(1);
        end
      end else begin
        err_d[0] = 1'b1;
      end
    end

    if (rd_issue) begin
      dout_d     = rd_data;
      dout_vld_d = 1'b1;
      done_d     = rd_last;
      if (ra_ovf) begin
        err_d[0] = 1'b1;
      end
    end

`ifndef INTLV_QUAD_BUF_LEN_CHK_EN
    err_d[1] = 1'b0;
`endif
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign done     = done_q;
  assign busy     = (state_q != ST_IDLE);
  assign err      = err_q;

endmodule
